pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumer end of the PLL lock interface: takes the asynchronous PLL LOCK output and produces clean, synchronous, staged reset releases for the 96 MHz domain.
- Runs on the PLL output clock.
- Holds the core and USB logic in reset until lock has been continuously stable.
- Re-asserts both resets on any lock loss, and counts lock-loss events for debug.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock samples required before the core reset is released (must be ≥2).
- STAGE_DELAY, 16: clock edges between core reset release and USB reset release (must be ≥1).
- CNT_W, 11: width of the internal cycle counter; must hold max(LOCK_STABLE_CYCLES, STAGE_DELAY).

Ports:
- clk  input  1  PLL output clock (96 MHz); all logic on rising edge.
- rst  input  1  asynchronous, active-high global reset.
- pll_locked  input  1  PLL LOCK, asynchronous to clk, may glitch.
- rst_core_out  output  1  active-high reset to the core domain.
- rst_usb_out  output  1  active-high reset to the USB domain.
- ready  output  1  high when both resets are released.
- lock_lost  output  1  one-cycle pulse on loss of lock after release.
- lock_loss_count  output  8  saturating count of lock_lost pulses.

Behaviour:
- Reset values (rst=1, applied asynchronously):
  - rst_core_out=1, rst_usb_out=1.
  - ready=0, lock_lost=0, lock_loss_count=0.
  - Sync flops=0, counter=0, state=WAIT_LOCK.
- Synchronizer: two-flop synchronizer on pll_locked gives lock_s. Only lock_s is used downstream.
- All outputs are registered. No combinational path from input to output.
- State WAIT_LOCK:
  - counter=0; both resets asserted; ready=0.
  - lock_s=1: go to STABLE with counter=1.
- State STABLE:
  - lock_s=1: counter increments.
  - lock_s=0: return to WAIT_LOCK and clear the counter. No lock_lost pulse and no count, because the resets were never released.
  - lock_s=1 with counter==LOCK_STABLE_CYCLES-1: go to RELEASE_CORE; rst_core_out goes 0 on that edge; counter clears.
- State RELEASE_CORE:
  - rst_core_out=0, rst_usb_out=1; counter increments.
  - counter==STAGE_DELAY-1: go to RUN; rst_usb_out=0 and ready=1 on that edge.
- State RUN:
  - All resets released; ready=1.
  - Holds indefinitely while lock_s=1.
- Lock loss: lock_s=0 in RELEASE_CORE or RUN causes, on the next edge:
  - state=WAIT_LOCK;
  - rst_core_out=1, rst_usb_out=1, ready=0;
  - lock_lost=1 for exactly one cycle;
  - lock_loss_count increments, saturating at 255 (no wrap).
- Timing:
  - pll_locked rising edge to lock_s=1: 2 edges.
  - rst_core_out falls on the edge where lock_s has been sampled 1 on LOCK_STABLE_CYCLES consecutive edges.
  - rst_usb_out and ready fall/rise exactly STAGE_DELAY edges after rst_core_out falls.
- Glitches: a lock glitch shorter than one clock period may or may not be captured. If captured, it is treated as a full loss.
- Reset mid-operation: rst asserted in any state immediately forces the reset values, including clearing lock_loss_count.
- rst deassert: with pll_locked already high, the sequence starts from WAIT_LOCK as for a fresh lock.

Test Plan (LOCK_STABLE_CYCLES=8, STAGE_DELAY=4):
- Clean start: rst released, pll_locked=1 before edge 0 → rst_core_out falls at edge 9, rst_usb_out and ready at edge 13, lock_lost never pulses, lock_loss_count=0.
- Early dropout: pll_locked high for 5 edges, then low 3 edges, then high → no lock_lost, count stays 0, full 8-sample stability restarts; rst_core_out falls 8 edges after lock_s re-asserts.
- Loss in RUN: after ready=1, drop pll_locked for 4 cycles → 2 edges sync + 1 edge later both resets=1, ready=0, lock_lost high exactly 1 cycle, count=1; re-lock re-releases with identical timing as clean start.
- Loss in RELEASE_CORE: drop lock 2 edges after rst_core_out falls → rst_core_out re-asserts, rst_usb_out never deasserts, count=1.
- Saturation: force 260 lock-loss events → lock_loss_count=255 and holds; lock_lost still pulses each event.
- Async reset mid-RUN: assert rst between edges → all outputs take reset values before the next edge, count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Turns the asynchronous PLL LOCK signal into staged, synchronous reset
// releases for the PLL output clock domain. The core reset is released once
// the synchronized lock has been high for LOCK_STABLE_CYCLES consecutive
// edges. The USB reset follows STAGE_DELAY edges later. Any loss of lock after
// the core reset has been released re-asserts both resets, emits a one-cycle
// lock_lost pulse and bumps a saturating debug counter.
//
// Ports:
//   clk             PLL output clock, all logic on the rising edge
//   rst             asynchronous active-high global reset
//   pll_locked      raw PLL LOCK, asynchronous to clk, may glitch
//   rst_core_out    active-high reset to the core domain (registered)
//   rst_usb_out     active-high reset to the USB domain (registered)
//   ready           high while both resets are released (registered)
//   lock_lost       one-cycle pulse on loss of lock after release (registered)
//   lock_loss_count saturating count of lock_lost pulses (registered)
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_DELAY        = 16,
   parameter int CNT_W              = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       rst_core_out,
   output logic       rst_usb_out,
   output logic       ready,
   output logic       lock_lost,
   output logic [7:0] lock_loss_count
);

   typedef enum logic [1:0] {
      WAIT_LOCK    = 2'd0,
      STABLE       = 2'd1,
      RELEASE_CORE = 2'd2,
      RUN          = 2'd3
   } state_t;

   // Terminal counter values for the two timed states.
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);

   // Saturating increment for the 8-bit debug counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   logic             sync1_r;
   logic             lock_s;
   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             loss_s;
   logic             rst_core_r;
   logic             rst_usb_r;
   logic             ready_r;
   logic             lock_lost_r;
   logic [7:0]       loss_cnt_r;
   logic [7:0]       loss_cnt_s;

   // Two-flop synchronizer for the asynchronous LOCK input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync1_r <= pll_locked;
         lock_s  <= sync1_r;
      end
   end

   // Next-state, counter and lock-loss detection.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      loss_s  = 1'b0;
      case (state_r)
         WAIT_LOCK: begin
            // The first good sample already counts toward stability.
            if (lock_s) begin
               state_s = STABLE;
               cnt_s   = CNT_W'(1);
            end else begin
               cnt_s   = '0;
            end
         end
         STABLE: begin
            // Resets were never released here, so a drop is not a loss event.
            if (!lock_s) begin
               state_s = WAIT_LOCK;
               cnt_s   = '0;
            end else if (cnt_r == STABLE_LAST) begin
               state_s = RELEASE_CORE;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
            end
         end
         RELEASE_CORE: begin
            // Loss of lock takes priority over advancing to RUN.
            if (!lock_s) begin
               state_s = WAIT_LOCK;
               cnt_s   = '0;
               loss_s  = 1'b1;
            end else if (cnt_r == STAGE_LAST) begin
               state_s = RUN;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_s = WAIT_LOCK;
               cnt_s   = '0;
               loss_s  = 1'b1;
            end else begin
               cnt_s   = '0;
            end
         end
         default: begin
            state_s = WAIT_LOCK;
            cnt_s   = '0;
         end
      endcase
   end

   // Debug counter next value.
   always_comb begin
      loss_cnt_s = loss_cnt_r;
      if (loss_s) begin
         loss_cnt_s = sat_inc8(loss_cnt_r);
      end else begin
         loss_cnt_s = loss_cnt_r;
      end
   end

   // State, counter and registered outputs; outputs are decoded from the
   // next state so they change on the same edge as the state transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= WAIT_LOCK;
         cnt_r       <= '0;
         rst_core_r  <= 1'b1;
         rst_usb_r   <= 1'b1;
         ready_r     <= 1'b0;
         lock_lost_r <= 1'b0;
         loss_cnt_r  <= 8'd0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         rst_core_r  <= (state_s == WAIT_LOCK) || (state_s == STABLE);
         rst_usb_r   <= (state_s != RUN);
         ready_r     <= (state_s == RUN);
         lock_lost_r <= loss_s;
         loss_cnt_r  <= loss_cnt_s;
      end
   end

   assign rst_core_out    = rst_core_r;
   assign rst_usb_out     = rst_usb_r;
   assign ready           = ready_r;
   assign lock_lost       = lock_lost_r;
   assign lock_loss_count = loss_cnt_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Scoreboard bench for pll_reset_sequencer with LOCK_STABLE_CYCLES=8 and
// STAGE_DELAY=4. Each driven pll_locked value is fed through a two-deep
// history (the synchronizer latency) into a streak-based reference model
// whose expected outputs are queued, then popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int N = 8;
   localparam int D = 4;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       rst_core_out;
   logic       rst_usb_out;
   logic       ready;
   logic       lock_lost;
   logic [7:0] lock_loss_count;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(N),
      .STAGE_DELAY       (D),
      .CNT_W             (11)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pll_locked     (pll_locked),
      .rst_core_out   (rst_core_out),
      .rst_usb_out    (rst_usb_out),
      .ready          (ready),
      .lock_lost      (lock_lost),
      .lock_loss_count(lock_loss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   // reference model state
   int   m_streak;
   logic m_core;
   logic m_usb;
   logic m_ready;
   logic m_lost;
   int   m_count;
   logic hist_q[$];
   logic [11:0] exp_q[$];

   // per-phase observations
   int step_idx;
   int lost_seen;
   int core_fall;
   int ready_rise;
   int usb_low_seen;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_streak = 0;
      m_core   = 1'b1;
      m_usb    = 1'b1;
      m_ready  = 1'b0;
      m_lost   = 1'b0;
      m_count  = 0;
      hist_q.delete();
      exp_q.delete();
      hist_q.push_back(1'b0);
      hist_q.push_back(1'b0);
      step_idx     = 0;
      lost_seen    = 0;
      core_fall    = -1;
      ready_rise   = -1;
      usb_low_seen = 0;
   endtask

   task automatic clear_obs();
      step_idx     = 0;
      lost_seen    = 0;
      core_fall    = -1;
      ready_rise   = -1;
      usb_low_seen = 0;
   endtask

   // Drive one lock value for one edge, queue the expectation, compare after.
   task automatic step(input logic pl, input string tag);
      logic l;
      logic [11:0] got;
      pll_locked = pl;
      hist_q.push_back(pl);
      l = hist_q.pop_front();
      if (!l) begin
         m_lost = !m_core;
         if (m_lost && m_count < 255) m_count++;
         m_streak = 0;
         m_core   = 1'b1;
         m_usb    = 1'b1;
         m_ready  = 1'b0;
      end else begin
         m_lost = 1'b0;
         if (m_streak < N + D) m_streak++;
         m_core  = (m_streak < N);
         m_usb   = (m_streak < N + D);
         m_ready = (m_streak >= N + D);
      end
      exp_q.push_back({m_core, m_usb, m_ready, m_lost, 8'(m_count)});
      @(posedge clk);
      @(negedge clk);
      got = {rst_core_out, rst_usb_out, ready, lock_lost, lock_loss_count};
      check_eq(tag, 32'(got), 32'(exp_q.pop_front()));
      if (lock_lost) lost_seen++;
      if (!rst_core_out && core_fall < 0) core_fall = step_idx;
      if (ready && ready_rise < 0) ready_rise = step_idx;
      if (!rst_usb_out) usb_low_seen++;
      step_idx++;
   endtask

   // Assert rst between edges, check reset values before the next edge, release.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      check_eq({tag, "_outs"}, 32'({rst_core_out, rst_usb_out, ready, lock_lost}), 32'(4'b1100));
      check_eq({tag, "_count"}, 32'(lock_loss_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      pll_locked = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset("por");

      // clean start
      for (int i = 0; i < 16; i++) step(1'b1, "clean");
      check_eq("clean_core_fall", 32'(core_fall), 32'd9);
      check_eq("clean_ready_rise", 32'(ready_rise), 32'd13);
      check_eq("clean_no_lost", 32'(lost_seen), 32'd0);

      // loss in RUN, then re-lock
      clear_obs();
      for (int i = 0; i < 4; i++) step(1'b0, "run_loss");
      check_eq("run_loss_pulses", 32'(lost_seen), 32'd1);
      check_eq("run_loss_count", 32'(lock_loss_count), 32'd1);
      clear_obs();
      for (int i = 0; i < 16; i++) step(1'b1, "relock");
      check_eq("relock_core_fall", 32'(core_fall), 32'd9);
      check_eq("relock_ready_rise", 32'(ready_rise), 32'd13);

      // early dropout from a fresh reset
      do_reset("rst2");
      for (int i = 0; i < 5; i++) step(1'b1, "early");
      for (int i = 0; i < 3; i++) step(1'b0, "early");
      for (int i = 0; i < 14; i++) step(1'b1, "early");
      check_eq("early_core_fall", 32'(core_fall), 32'd17);
      check_eq("early_no_lost", 32'(lost_seen), 32'd0);
      check_eq("early_count", 32'(lock_loss_count), 32'd0);

      // loss two edges after core release
      do_reset("rst3");
      for (int i = 0; i < 9; i++) step(1'b1, "relcore");
      for (int i = 0; i < 3; i++) step(1'b0, "relcore");
      check_eq("relcore_core_fall", 32'(core_fall), 32'd9);
      check_eq("relcore_usb_never_low", 32'(usb_low_seen), 32'd0);
      check_eq("relcore_count", 32'(lock_loss_count), 32'd1);
      check_eq("relcore_core_back", 32'(rst_core_out), 32'd1);

      // saturation: 260 loss events
      do_reset("rst4");
      for (int e = 0; e < 260; e++) begin
         for (int i = 0; i < 10; i++) step(1'b1, "sat");
         for (int i = 0; i < 3; i++) step(1'b0, "sat");
      end
      check_eq("sat_pulses", 32'(lost_seen), 32'd260);
      check_eq("sat_count", 32'(lock_loss_count), 32'd255);

      // async reset mid-RUN, then restart with lock already high
      clear_obs();
      for (int i = 0; i < 16; i++) step(1'b1, "pre_rst");
      check_eq("pre_rst_ready", 32'(ready), 32'd1);
      check_eq("pre_rst_count", 32'(lock_loss_count), 32'd255);
      do_reset("mid_run");
      for (int i = 0; i < 16; i++) step(1'b1, "restart");
      check_eq("restart_core_fall", 32'(core_fall), 32'd9);
      check_eq("restart_ready_rise", 32'(ready_rise), 32'd13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
